// File: rtl/gate_selftest_seq_if.sv
// Bus between the gate self-test sequencer and its environment: the run
// control/result signals plus the stimulus and response of the gate block.
//
// Handshake: `start` is a level sampled only while the sequencer is idle (an
// accepted start begins a run on that edge); `busy` is high for the whole run;
// `done` is a single-cycle pulse marking completion, from which `pass`,
// `err_count` and `fail_mask` are valid and held until the next accepted start.
interface gate_selftest_seq_if;
   logic       start;
   logic       y1_and;
   logic       y2_or;
   logic       y3_nand;
   logic       y4_nor;
   logic       y5_xor;
   logic       y6_xnor;
   logic       y7_not;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] fail_mask;
   logic [1:0] state_dbg;

   // Sequencer side: drives stimulus and results, consumes start and gate outputs.
   modport master (
      input  start, y1_and, y2_or, y3_nand, y4_nor, y5_xor, y6_xnor, y7_not,
      output a, b, busy, done, pass, err_count, fail_mask, state_dbg
   );

   // Environment side: requests runs and hosts the gate block under test.
   modport slave (
      output start, y1_and, y2_or, y3_nand, y4_nor, y5_xor, y6_xnor, y7_not,
      input  a, b, busy, done, pass, err_count, fail_mask, state_dbg
   );
endinterface

// File: rtl/gate_selftest_seq.sv
// Sequential self-test driver for a two-input gate block. Walks the four a/b
// combinations, lets each settle SETTLE_CYCLES cycles, checks all seven gate
// outputs against locally computed values and reports a per-vector fail mask,
// an error count and a pass flag. Every output is a register.
module gate_selftest_seq #(
   parameter int unsigned SETTLE_CYCLES = 2   // legal 1..15
) (
   input logic                 clk,
   input logic                 rst_n,
   gate_selftest_seq_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state,      state_nxt;
   logic [1:0] vec_idx,    vec_nxt;
   logic [3:0] settle_cnt, cnt_nxt;
   logic       a_q,        a_nxt;
   logic       b_q,        b_nxt;
   logic       busy_q,     busy_nxt;
   logic       done_q,     done_nxt;
   logic       pass_q,     pass_nxt;
   logic [2:0] err_q,      err_nxt;
   logic [3:0] mask_q,     mask_nxt;

   logic [6:0] exp_vec;
   logic [6:0] got_vec;
   logic       mismatch;

   // Reference gate values for the stimulus currently on a/b, and the mismatch flag.
   always_comb begin
      exp_vec  = {a_q & b_q, a_q | b_q, ~(a_q & b_q), ~(a_q | b_q),
                  a_q ^ b_q, ~(a_q ^ b_q), ~a_q};
      got_vec  = {bus.y1_and, bus.y2_or, bus.y3_nand, bus.y4_nor,
                  bus.y5_xor, bus.y6_xnor, bus.y7_not};
      mismatch = (got_vec != exp_vec);
   end

   // Next-state and next-output logic; outputs hold unless a state acts on them.
   always_comb begin
      state_nxt = state;
      vec_nxt   = vec_idx;
      cnt_nxt   = settle_cnt;
      a_nxt     = a_q;
      b_nxt     = b_q;
      busy_nxt  = busy_q;
      done_nxt  = 1'b0;
      pass_nxt  = pass_q;
      err_nxt   = err_q;
      mask_nxt  = mask_q;

      case (state)
         IDLE: begin
            a_nxt    = 1'b0;
            b_nxt    = 1'b0;
            busy_nxt = 1'b0;
            if (bus.start) begin
               state_nxt = SETTLE;
               vec_nxt   = 2'd0;
               cnt_nxt   = 4'd0;
               busy_nxt  = 1'b1;
               err_nxt   = 3'd0;
               mask_nxt  = 4'd0;
               pass_nxt  = 1'b0;
            end
         end
         SETTLE: begin
            cnt_nxt = settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST) begin
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            // A vector counts once however many of its seven bits are wrong.
            if (mismatch) begin
               err_nxt           = err_q + 3'd1;
               mask_nxt[vec_idx] = 1'b1;
            end
            if (vec_idx != 2'd3) begin
               vec_nxt        = vec_idx + 2'd1;
               {a_nxt, b_nxt} = vec_idx + 2'd1;
               cnt_nxt        = 4'd0;
               state_nxt      = SETTLE;
            end else begin
               // pass is registered on entry to DONE, so it must include the
               // verdict of the final vector being checked right now.
               state_nxt = DONE;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               a_nxt     = 1'b0;
               b_nxt     = 1'b0;
               pass_nxt  = !mismatch && (err_q == 3'd0);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         vec_idx    <= 2'd0;
         settle_cnt <= 4'd0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= 3'd0;
         mask_q     <= 4'd0;
      end else begin
         state      <= state_nxt;
         vec_idx    <= vec_nxt;
         settle_cnt <= cnt_nxt;
         a_q        <= a_nxt;
         b_q        <= b_nxt;
         busy_q     <= busy_nxt;
         done_q     <= done_nxt;
         pass_q     <= pass_nxt;
         err_q      <= err_nxt;
         mask_q     <= mask_nxt;
      end
   end

   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_mask = mask_q;
   assign bus.state_dbg = state;

endmodule

// File: doc/gate_selftest_seq.md
# gate_selftest_seq

Sequential built-in self-test driver for the two-input `basic_gates` block. On `start`, it drives all four `a`/`b` combinations into the gate block in turn and lets each settle. It then samples the seven gate outputs, compares them against internally computed expected values, and reports a per-vector fail mask, an error count and a pass flag. It sits directly upstream and downstream of `basic_gates`: it generates that block's inputs and consumes its outputs.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range 1..15. The settle counter is 4 bits.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: starts a test run. Sampled only in IDLE.
- `y1_and`, `y2_or`, `y3_nand`, `y4_nor`, `y5_xor`, `y6_xnor`, `y7_not` input 1 each: outputs of the gate block under test.
- `a`, `b` output 1 each: registered stimulus to the gate block.
- `busy` output 1: high while a run is in progress (SETTLE or CHECK).
- `done` output 1: one-cycle pulse when a run completes.
- `pass` output 1: high when the last completed run had zero errors.
- `err_count` output 3: number of failing vectors in the last run, 0..4.
- `fail_mask` output 4: bit i is set if vector i failed. Vector i drives `a`=i[1] and `b`=i[0].

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - `a`=`b`=0, `busy`=0.
  - `start`=1 → SETTLE, with vec_idx=0, `a`=0, `b`=0, settle_cnt=0.
  - In the same edge, clear `err_count`, `fail_mask` and `pass`.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES-1 → CHECK.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK, one cycle:
  - Compare the inputs against the expected values computed from the current `a`,`b`: and=a&b, or=a|b, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b), not=~a.
  - Any mismatch on any of the 7 bits: `err_count`+1 and `fail_mask`[vec_idx]=1. Each vector counts at most once.
  - vec_idx<3: vec_idx+1, `a`/`b` take the new index, settle_cnt=0, → SETTLE.
  - vec_idx==3: → DONE.
- DONE, one cycle:
  - `done`=1, `busy`=0.
  - `pass` = (`err_count`==0).
  - `a`,`b` return to 0.
  - → IDLE.
- `err_count`, `fail_mask` and `pass` hold their values until the next accepted `start`.
- `start` is ignored in SETTLE, CHECK and DONE. Holding `start` high continuously triggers a new run on the first IDLE cycle after DONE.
- Reset, including mid-run: asynchronous return to IDLE, abandoning the run. No `done` pulse is produced.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0, state IDLE, vec_idx=0, settle_cnt=0.
- All outputs are registered. No combinational path from the inputs to any output.
- Edge E0 samples `start`=1; `busy` rises after E0.
- A run occupies 4×(SETTLE_CYCLES+1) cycles of SETTLE and CHECK.
- `done` is high for the single cycle following that window. For SETTLE_CYCLES=2, `done` is high in cycle 12 after E0, with `busy` high for cycles 0–11.
- `pass` is valid from the `done` cycle onward.
- A new vector appears on `a`/`b` at the edge leaving CHECK. The gate outputs are sampled during the last cycle of CHECK, so they have SETTLE_CYCLES+1 cycles to settle.
- Earliest restart: `start` sampled on the edge after DONE, i.e. the first IDLE cycle.

## Test plan
- Healthy gate block, SETTLE_CYCLES=2, pulse `start` → `a`/`b` sequence 00,01,10,11. `done` pulses once, 12 cycles after `busy` rises. Result: `pass`=1, `err_count`=0, `fail_mask`=4'b0000.
- `y5_xor` forced to 0 → vectors 01 and 10 fail. Result: `err_count`=2, `fail_mask`=4'b0110, `pass`=0.
- `y7_not` inverted and `y1_and` forced to 1 at the same time → every vector fails, each counted once. Result: `err_count`=4, `fail_mask`=4'b1111.
- `start` re-pulsed mid-run, then held high → mid-run pulse is ignored and the run completes at the normal time. A second run starts right after DONE and clears the previous `err_count`/`fail_mask` at its start edge.
- `rst_n` asserted while vector 10 is settling → all outputs go to 0 immediately, state returns to IDLE, and no `done` pulse occurs. A subsequent `start` runs cleanly from vector 00.
- SETTLE_CYCLES=1 → `done` 8 cycles after `busy` rises, and each vector is held for 2 cycles.
